sol1_bus_responder: RTL
=======================

// Module: sol1_bus_responder
// PURPOSE
//  Bus-side counterpart of the SOL-1 CPU external bus. Decodes addr/rd/wr/mem_io and serves
//  memory cycles from an internal RAM and I/O cycles from a small register window.
//  Stretches every cycle via WAIT and returns read data on data_in.
//  Contains a RAM-to-RAM block-copy DMA engine that takes the bus through dma_req/dma_ack.
// PARAMETERS
//  MEM_DEPTH    256  RAM bytes (>=256, power of 2); RAM index = addr[$clog2(MEM_DEPTH)-1:0]
//  WAIT_CYCLES  2    extra BUSY cycles per CPU access (0..15)
//  IO_BASE      5'h1F I/O window select, matched against addr[7:3]
// PORTS
//  clk          in   1   clock, rising edge
//  arst         in   1   reset, asynchronous, active-high
//  addr         in   22  CPU address
//  data_out     in   8   CPU write data
//  rd           in   1   CPU read strobe, held until WAIT low
//  wr           in   1   CPU write strobe, held until WAIT low
//  mem_io       in   1   1=memory cycle, 0=I/O cycle
//  dma_ack      in   1   CPU has released the bus
//  data_in      out  8   read data to CPU
//  WAIT         out  1   stall CPU bus cycle (combinational)
//  dma_req      out  1   DMA bus request
//  irq_dma      out  1   level interrupt: done & irq_en
// BEHAVIOUR
//  Reset: data_in=8'hFF, WAIT=0, dma_req=0, irq_dma=0, bus FSM=IDLE, DMA FSM=D_IDLE.
//   src/dst/len/ctrl/done=0. RAM contents are not reset.
//  Bus FSM IDLE->BUSY->DONE->IDLE. Strobes are ignored while dma_ack=1.
//  IDLE: (rd|wr)=1 -> latch addr/mem_io/data_out/op; cnt=WAIT_CYCLES; ->BUSY.
//  BUSY: cnt!=0 -> cnt--. cnt==0 -> perform access; ->DONE.
//   Read: data_in<=value. Write: RAM/register updated on that edge.
//  DONE: stay while (rd|wr)=1; else ->IDLE.
//  WAIT=(rd|wr)&~dma_ack&(state==IDLE|state==BUSY). A CPU cycle therefore sees WAIT_CYCLES+2
//   WAIT cycles. data_in is valid from the first WAIT-low cycle and holds until the next read.
//  rd&wr both 1: treat as write.
//  Memory map: index >= MEM_DEPTH, i.e. addr[21:$clog2(MEM_DEPTH)]!=0 -> read 8'hFF, write dropped.
//  I/O cycle with addr[7:3]!=IO_BASE -> read 8'hFF, write dropped. Register map by addr[2:0]:
//   0 STATUS ro: {6'b0,done,busy}. A read returns the current value, then clears done.
//   1 CTRL: bit0 start (write-1 self-clearing, reads 0); bit1 irq_en (r/w).
//   2 SRC; 3 DST; 4 LEN, each r/w 8 bits. 5-7 read 8'h00, writes dropped.
//  DMA FSM D_IDLE->D_REQ->D_RD->D_WR->...->D_REL->D_IDLE.
//   busy = (DMA FSM != D_IDLE).
//  start with busy=1: ignored. start with len=0: done<=1, no request.
//  start with len!=0: latch start, taken when bus FSM reaches DONE->IDLE; ->D_REQ.
//   The CPU write that set start completes normally first.
//  D_REQ: dma_req=1; wait for dma_ack=1 -> D_RD.
//  D_RD: tmp<=RAM[src] -> D_WR.
//  D_WR: RAM[dst]<=tmp; src++, dst++ (8-bit wrap 8'hFF->8'h00); len--.
//   len==1 before the decrement -> D_REL; else -> D_RD. Rate is 2 clk per byte.
//  D_REL: dma_req=0; done<=1 on entry; wait dma_ack=0 -> D_IDLE.
//  SRC/DST/LEN read back live progress. CPU writes to them while busy are dropped.
//  Overlapping src/dst copies forward, byte by byte, with no hazard handling.
//  irq_dma = done & irq_en, registered.
//  dma_ack dropping early in D_RD/D_WR: finish the current byte, then ->D_REL.
//  Reset mid-operation aborts both FSMs immediately. A partial copy is left in RAM.
// TESTING
//  T1 WAIT_CYCLES=2, mem write 0x0010<=8'hA5, then read 0x0010:
//   WAIT high exactly 4 clk per cycle; data_in=8'hA5.
//  T2 Read mem addr 22'h100000 -> data_in=8'hFF.
//   I/O write to addr[7:3]!=IO_BASE changes no register.
//  T3 Program SRC=8'hFE, DST=8'h40, LEN=3, CTRL=3:
//   dma_req rises; after dma_ack, RAM[40..42]=RAM[FE,FF,00] in 6 clk.
//   dma_req falls; irq_dma=1; STATUS read=8'h02, then 8'h00, and irq_dma falls.
//  T4 LEN=0, start -> done=1 next cycle, dma_req never asserted.
//  T5 Start while busy, or write SRC while busy -> ignored, copy unaffected.
//   Strobes with dma_ack=1 never assert WAIT.
//  T6 arst pulse during D_WR with dma_req=1:
//   dma_req=0, WAIT=0, data_in=8'hFF same cycle; STATUS reads 8'h00 afterwards.

Source files
------------

// File: rtl/sol1_bus_responder_if.sv
`default_nettype none
// ============================================================
// sol1_bus_responder_if: SOL-1 external bus signal bundle
// Rev 1.0
// ============================================================
interface sol1_bus_responder_if;
  logic [21:0] addr;
  logic [7:0]  data_out;
  logic        rd;
  logic        wr;
  logic        mem_io;
  logic        dma_ack;
  logic [7:0]  data_in;
  logic        WAIT;
  logic        dma_req;
  logic        irq_dma;

  modport master (
    output addr, data_out, rd, wr, mem_io, dma_ack,
    input  data_in, WAIT, dma_req, irq_dma
  );

  modport slave (
    input  addr, data_out, rd, wr, mem_io, dma_ack,
    output data_in, WAIT, dma_req, irq_dma
  );
endinterface
`default_nettype wire

// File: rtl/sol1_bus_responder.sv
`default_nettype none
// ============================================================
// sol1_bus_responder: SOL-1 bus slave with RAM, I/O regs, DMA
// Rev 1.0
// ============================================================
module sol1_bus_responder #(
  parameter int         MEM_DEPTH   = 256,
  parameter int         WAIT_CYCLES = 2,
  parameter logic [4:0] IO_BASE     = 5'h1F
) (
  input  logic                 clk,
  input  logic                 arst,
  sol1_bus_responder_if.slave  bus
);

  localparam int AW = $clog2(MEM_DEPTH);

  localparam logic [1:0] c_bus_idle = 2'd0;
  localparam logic [1:0] c_bus_busy = 2'd1;
  localparam logic [1:0] c_bus_done = 2'd2;

  localparam logic [2:0] c_d_idle = 3'd0;
  localparam logic [2:0] c_d_req  = 3'd1;
  localparam logic [2:0] c_d_rd   = 3'd2;
  localparam logic [2:0] c_d_wr   = 3'd3;
  localparam logic [2:0] c_d_rel  = 3'd4;

  logic [1:0]  bus_state_q, bus_state_d;
  logic [3:0]  cnt_q;
  logic [21:0] addr_q;
  logic [7:0]  wdata_q;
  logic        mem_io_q;
  logic        is_wr_q;
  logic [7:0]  data_in_q;

  logic [2:0]  dma_state_q, dma_state_d;
  logic [7:0]  src_q, dst_q, len_q, tmp_q;
  logic        done_q, irq_en_q, start_pend_q, irq_q;

  logic [7:0]  mem_q [MEM_DEPTH];

  logic        w_strobe;
  logic        w_access;
  logic        w_mem_hit;
  logic        w_io_hit;
  logic        w_cpu_mem_wr;
  logic        w_reg_wr;
  logic        w_status_rd;
  logic        w_busy;
  logic        w_bus_release;
  logic        w_take;
  logic [7:0]  w_rdata;

  assign w_strobe      = (bus.rd | bus.wr) & ~bus.dma_ack;
  assign w_access      = (bus_state_q == c_bus_busy) && (cnt_q == 4'd0);
  assign w_mem_hit     = mem_io_q && (addr_q[21:AW] == '0);
  assign w_io_hit      = !mem_io_q && (addr_q[7:3] == IO_BASE);
  assign w_cpu_mem_wr  = w_access && is_wr_q && w_mem_hit;
  assign w_reg_wr      = w_access && is_wr_q && w_io_hit;
  assign w_status_rd   = w_access && !is_wr_q && w_io_hit && (addr_q[2:0] == 3'd0);
  assign w_busy        = (dma_state_q != c_d_idle);
  assign w_bus_release = (bus_state_q == c_bus_done) && !(bus.rd | bus.wr);
  assign w_take        = (dma_state_q == c_d_idle) && start_pend_q && w_bus_release;

  assign bus.data_in = data_in_q;
  assign bus.WAIT    = w_strobe &&
                       ((bus_state_q == c_bus_idle) || (bus_state_q == c_bus_busy));
  assign bus.dma_req = (dma_state_q == c_d_req) || (dma_state_q == c_d_rd) ||
                       (dma_state_q == c_d_wr);
  assign bus.irq_dma = irq_q;

  always_comb begin
    w_rdata = 8'hFF;
    if (mem_io_q) begin
      if (addr_q[21:AW] == '0) w_rdata = mem_q[addr_q[AW-1:0]];
    end else if (w_io_hit) begin
      case (addr_q[2:0])
        3'd0:    w_rdata = {6'b0, done_q, w_busy};
        3'd1:    w_rdata = {6'b0, irq_en_q, 1'b0};
        3'd2:    w_rdata = src_q;
        3'd3:    w_rdata = dst_q;
        3'd4:    w_rdata = len_q;
        default: w_rdata = 8'h00;
      endcase
    end
  end

  always_comb begin
    bus_state_d = bus_state_q;
    case (bus_state_q)
      c_bus_idle: if (w_strobe) bus_state_d = c_bus_busy;
      c_bus_busy: if (cnt_q == 4'd0) bus_state_d = c_bus_done;
      c_bus_done: if (!(bus.rd | bus.wr)) bus_state_d = c_bus_idle;
      default:    bus_state_d = c_bus_idle;
    endcase
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      bus_state_q <= c_bus_idle;
      cnt_q       <= 4'd0;
      addr_q      <= 22'd0;
      wdata_q     <= 8'd0;
      mem_io_q    <= 1'b0;
      is_wr_q     <= 1'b0;
      data_in_q   <= 8'hFF;
    end else begin
      bus_state_q <= bus_state_d;
      if ((bus_state_q == c_bus_idle) && w_strobe) begin
        addr_q   <= bus.addr;
        wdata_q  <= bus.data_out;
        mem_io_q <= bus.mem_io;
        is_wr_q  <= bus.wr;
        cnt_q    <= 4'(WAIT_CYCLES);
      end else if ((bus_state_q == c_bus_busy) && (cnt_q != 4'd0)) begin
        cnt_q <= cnt_q - 4'd1;
      end
      if (w_access && !is_wr_q) data_in_q <= w_rdata;
    end
  end

  // An early dma_ack drop still lets the byte in flight complete before release.
  always_comb begin
    dma_state_d = dma_state_q;
    case (dma_state_q)
      c_d_idle: if (w_take && (len_q != 8'd0)) dma_state_d = c_d_req;
      c_d_req:  if (bus.dma_ack) dma_state_d = c_d_rd;
      c_d_rd:   dma_state_d = c_d_wr;
      c_d_wr:   dma_state_d = ((len_q == 8'd1) || !bus.dma_ack) ? c_d_rel : c_d_rd;
      c_d_rel:  if (!bus.dma_ack) dma_state_d = c_d_idle;
      default:  dma_state_d = c_d_idle;
    endcase
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      dma_state_q  <= c_d_idle;
      src_q        <= 8'd0;
      dst_q        <= 8'd0;
      len_q        <= 8'd0;
      tmp_q        <= 8'd0;
      done_q       <= 1'b0;
      irq_en_q     <= 1'b0;
      start_pend_q <= 1'b0;
      irq_q        <= 1'b0;
    end else begin
      dma_state_q <= dma_state_d;
      irq_q       <= done_q & irq_en_q;
      if (w_reg_wr) begin
        case (addr_q[2:0])
          3'd1: begin
            irq_en_q <= wdata_q[1];
            if (wdata_q[0] && !w_busy) begin
              if (len_q == 8'd0) done_q <= 1'b1;
              else               start_pend_q <= 1'b1;
            end
          end
          3'd2:    if (!w_busy) src_q <= wdata_q;
          3'd3:    if (!w_busy) dst_q <= wdata_q;
          3'd4:    if (!w_busy) len_q <= wdata_q;
          default: ;
        endcase
      end
      if (w_take) begin
        start_pend_q <= 1'b0;
        if (len_q == 8'd0) done_q <= 1'b1;
      end
      if (dma_state_q == c_d_rd) tmp_q <= mem_q[AW'(src_q)];
      if (dma_state_q == c_d_wr) begin
        src_q <= src_q + 8'd1;
        dst_q <= dst_q + 8'd1;
        len_q <= len_q - 8'd1;
      end
      if (w_status_rd) done_q <= 1'b0;
      if ((dma_state_q == c_d_wr) && (dma_state_d == c_d_rel)) done_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (dma_state_q == c_d_wr) mem_q[AW'(dst_q)] <= tmp_q;
    else if (w_cpu_mem_wr)     mem_q[addr_q[AW-1:0]] <= wdata_q;
  end

endmodule
`default_nettype wire
